bullet_hit_scanner: RTL and testbench
=====================================

// Module: bullet_hit_scanner
// PURPOSE
//  Reader/consumer side of the bullet table: walks all 8 bullet slots through
//  the table's collision read port (index2 / position2 / size2 / color2 / isRender2).
//  Tests each rendered bullet against the player heart box and reports per-frame
//  damage, heal and hit mask to the HP/damage logic. Runs once per start pulse
//  (frame tick). Handshake: start in, busy/done out.
// PARAMETERS
//  DMG_WHITE   8'd4   damage per overlapping white (000) bullet
//  DMG_BLUE    8'd4   damage per overlapping blue (010) bullet while player moving
//  HEAL_GREEN  8'd2   heal per overlapping green (001) bullet
// PORTS
//  clk            in   1   system clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  start          in   1   scan request, sampled only in IDLE
//  player_x       in   8   heart box left edge
//  player_y       in   8   heart box top edge
//  player_w       in   8   heart box width (0 = no overlap possible)
//  player_h       in   8   heart box height
//  player_moving  in   1   player moved this frame (blue rule)
//  bul_index      out  3   slot index driven to table read port
//  bul_position   in   16  [15:8] = x, [7:0] = y of slot bul_index (comb. read)
//  bul_size       in   16  [15:8] = w, [7:0] = h
//  bul_color      in   3   000 white, 001 green, 010 blue, others inert
//  bul_render     in   1   slot active
//  busy           out  1   scan in progress
//  done           out  1   one-cycle pulse, results valid
//  damage         out  8   summed damage of last scan, saturating
//  heal           out  8   summed heal of last scan, saturating
//  hit_mask       out  8   bit i = slot i overlapped and had an active color
// BEHAVIOUR
//  Reset: state IDLE; bul_index=0, busy=0, done=0, damage=0, heal=0, hit_mask=0.
//  FSM: IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
//   IDLE : start=1 -> SCAN. Latch player_x/y/w/h/moving. Clear accumulators.
//          Set bul_index=0.
//   SCAN : each edge captures table outputs for bul_index into stage register.
//          Then bul_index+1. Capture of slot 7 -> DRAIN (bul_index returns to 0).
//   DRAIN: one cycle, evaluates slot 7.
//   DONE : done=1 for exactly this cycle -> IDLE.
//  Pipeline: stage 2 evaluates the slot captured one edge earlier.
//   Accumulators update on that same edge.
//  Timing: start sampled at edge E0; slot i captured at E(i+1), evaluated at E(i+2).
//   done high in the cycle after E9, i.e. a fixed 10-edge latency.
//  busy=1 in SCAN, DRAIN, DONE; 0 in IDLE.
//  Overlap, in 9-bit unsigned so sums never wrap:
//   bx < px+pw AND px < bx+bw AND by < py+ph AND py < by+bh.
//   Zero width or height never overlaps.
//  Slot counts only if bul_render=1 and overlap holds:
//   000 -> damage += DMG_WHITE, set mask bit.
//   010 -> if latched moving: damage += DMG_BLUE, set mask bit; else nothing.
//   001 -> heal += HEAL_GREEN, set mask bit.
//   011..111 -> nothing.
//  Sums saturate at 8'hFF.
//  damage/heal/hit_mask outputs load from accumulators at the E9 edge (entering DONE).
//   They hold until the next scan's DONE; not cleared by start.
//  start while busy: ignored; no queuing. start held high: rescans back-to-back,
//   re-entering SCAN from IDLE one cycle after DONE.
//  Player inputs change mid-scan: no effect (latched at start).
//  Async reset mid-scan: immediate return to reset values; partial results discarded.
// TESTING
//  1 Reset: rst_n=0 mid-SCAN -> busy=0, done=0, damage=heal=hit_mask=0, bul_index=0 at once.
//  2 Latency: start pulse at E0 -> bul_index 0..7 on E0..E7, done=1 only after E9, busy 10 cycles.
//  3 Player (16,16,16,16), white slot0 at (20,20,8,8), green slot1 at (10,10,8,8), others render=0
//    -> damage=4, heal=2, hit_mask=8'b0000_0011.
//  4 Edge touch: bullet x=32 w=8, player x=16 w=16 (px+pw=32) -> no hit; x=31 -> hit.
//    Blue overlap: moving=0 -> damage 0; moving=1 -> damage 4.
//  5 All 8 white overlapping, DMG_WHITE=8'd40 -> damage saturates 8'hFF, hit_mask=8'hFF.
//  6 start re-pulsed during SCAN -> ignored, single done; start held high -> done every 11 cycles.

Source files
------------

// File: rtl/bullet_hit_scanner.sv
// Walks the 8 bullet-table slots once per start pulse and sums damage, heal
// and a hit mask for every rendered bullet overlapping the player heart box.
module bullet_hit_scanner #(
  parameter logic [7:0] DMG_WHITE  = 8'd4,
  parameter logic [7:0] DMG_BLUE   = 8'd4,
  parameter logic [7:0] HEAL_GREEN = 8'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  player_x,
  input  logic [7:0]  player_y,
  input  logic [7:0]  player_w,
  input  logic [7:0]  player_h,
  input  logic        player_moving,
  output logic [2:0]  bul_index,
  input  logic [15:0] bul_position,
  input  logic [15:0] bul_size,
  input  logic [2:0]  bul_color,
  input  logic        bul_render,
  output logic        busy,
  output logic        done,
  output logic [7:0]  damage,
  output logic [7:0]  heal,
  output logic [7:0]  hit_mask,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t     state_q;
  logic [2:0] idx_q, sidx_q;
  logic [7:0] px_q, py_q, pw_q, ph_q;
  logic       mv_q;
  logic [7:0] sbx_q, sby_q, sbw_q, sbh_q;
  logic [2:0] scol_q;
  logic       srnd_q, svld_q;
  logic [7:0] dmg_acc_q, heal_acc_q, mask_acc_q;
  logic [7:0] dmg_acc_d, heal_acc_d, mask_acc_d;
  logic [7:0] damage_q, heal_q, mask_q;
  logic       done_q;

  logic [8:0] dmg_sum, heal_sum;
  logic [7:0] dmg_add, heal_add;
  logic       mask_bit, overlap, nonzero;

  // Edges compared in 9 bits so x+w near 255 cannot wrap into a false hit.
  always_comb begin
    overlap = ({1'b0, sbx_q} < ({1'b0, px_q} + {1'b0, pw_q})) &&
              ({1'b0, px_q} < ({1'b0, sbx_q} + {1'b0, sbw_q})) &&
              ({1'b0, sby_q} < ({1'b0, py_q} + {1'b0, ph_q})) &&
              ({1'b0, py_q} < ({1'b0, sby_q} + {1'b0, sbh_q}));
    nonzero = (pw_q != 8'd0) && (ph_q != 8'd0) && (sbw_q != 8'd0) && (sbh_q != 8'd0);
    dmg_add  = 8'd0;
    heal_add = 8'd0;
    mask_bit = 1'b0;
    if (svld_q && srnd_q && overlap && nonzero) begin
      case (scol_q)
        3'b000: begin dmg_add = DMG_WHITE; mask_bit = 1'b1; end
        3'b010: if (mv_q) begin dmg_add = DMG_BLUE; mask_bit = 1'b1; end
        3'b001: begin heal_add = HEAL_GREEN; mask_bit = 1'b1; end
        default: ;
      endcase
    end
    dmg_sum    = {1'b0, dmg_acc_q} + {1'b0, dmg_add};
    heal_sum   = {1'b0, heal_acc_q} + {1'b0, heal_add};
    dmg_acc_d  = dmg_sum[8] ? 8'hFF : dmg_sum[7:0];
    heal_acc_d = heal_sum[8] ? 8'hFF : heal_sum[7:0];
    mask_acc_d = mask_acc_q | ({7'd0, mask_bit} << sidx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      sidx_q     <= 3'd0;
      px_q       <= 8'd0;
      py_q       <= 8'd0;
      pw_q       <= 8'd0;
      ph_q       <= 8'd0;
      mv_q       <= 1'b0;
      sbx_q      <= 8'd0;
      sby_q      <= 8'd0;
      sbw_q      <= 8'd0;
      sbh_q      <= 8'd0;
      scol_q     <= 3'd0;
      srnd_q     <= 1'b0;
      svld_q     <= 1'b0;
      dmg_acc_q  <= 8'd0;
      heal_acc_q <= 8'd0;
      mask_acc_q <= 8'd0;
      damage_q   <= 8'd0;
      heal_q     <= 8'd0;
      mask_q     <= 8'd0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_SCAN;
            px_q       <= player_x;
            py_q       <= player_y;
            pw_q       <= player_w;
            ph_q       <= player_h;
            mv_q       <= player_moving;
            idx_q      <= 3'd0;
            svld_q     <= 1'b0;
            dmg_acc_q  <= 8'd0;
            heal_acc_q <= 8'd0;
            mask_acc_q <= 8'd0;
          end
        end
        S_SCAN: begin
          // Stage 1 captures the current slot while stage 2 scores the previous one.
          sbx_q      <= bul_position[15:8];
          sby_q      <= bul_position[7:0];
          sbw_q      <= bul_size[15:8];
          sbh_q      <= bul_size[7:0];
          scol_q     <= bul_color;
          srnd_q     <= bul_render;
          sidx_q     <= idx_q;
          svld_q     <= 1'b1;
          dmg_acc_q  <= dmg_acc_d;
          heal_acc_q <= heal_acc_d;
          mask_acc_q <= mask_acc_d;
          idx_q      <= idx_q + 3'd1;
          if (idx_q == 3'd7) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          dmg_acc_q  <= dmg_acc_d;
          heal_acc_q <= heal_acc_d;
          mask_acc_q <= mask_acc_d;
          damage_q   <= dmg_acc_d;
          heal_q     <= heal_acc_d;
          mask_q     <= mask_acc_d;
          svld_q     <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bul_index = idx_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign damage    = damage_q;
  assign heal      = heal_q;
  assign hit_mask  = mask_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bullet_hit_scanner.sv
// Bench for bullet_hit_scanner: vector table, hand sequences for timing and
// handshake corners, and randomized scans scored against a behavioural model.
module tb_bullet_hit_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic [7:0]  player_x, player_y, player_w, player_h;
  logic        player_moving;
  logic [7:0]  tx[8], ty[8], tw[8], th[8];
  logic [2:0]  tc[8];
  logic        tr[8];

  logic [2:0]  idx_a, idx_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [7:0]  dmg_a, heal_a, mask_a, dmg_b, heal_b, mask_b;
  logic [1:0]  st_a, st_b;

  int tests = 0;
  int fails = 0;

  bullet_hit_scanner dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .player_x(player_x), .player_y(player_y), .player_w(player_w), .player_h(player_h),
    .player_moving(player_moving), .bul_index(idx_a),
    .bul_position({tx[idx_a], ty[idx_a]}), .bul_size({tw[idx_a], th[idx_a]}),
    .bul_color(tc[idx_a]), .bul_render(tr[idx_a]),
    .busy(busy_a), .done(done_a), .damage(dmg_a), .heal(heal_a), .hit_mask(mask_a),
    .dbg_state(st_a)
  );

  bullet_hit_scanner #(.DMG_WHITE(8'd40)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .player_x(player_x), .player_y(player_y), .player_w(player_w), .player_h(player_h),
    .player_moving(player_moving), .bul_index(idx_b),
    .bul_position({tx[idx_b], ty[idx_b]}), .bul_size({tw[idx_b], th[idx_b]}),
    .bul_color(tc[idx_b]), .bul_render(tr[idx_b]),
    .busy(busy_b), .done(done_b), .damage(dmg_b), .heal(heal_b), .hit_mask(mask_b),
    .dbg_state(st_b)
  );

  typedef struct {
    logic [7:0] px, py, pw, ph;
    logic       mv;
    logic [7:0] bx, by, bw, bh;
    logic [2:0] col;
    logic       rnd;
    int         e_dmg, e_heal, e_mask;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_table();
    for (int s = 0; s < 8; s++) begin
      tx[s] = 8'd0; ty[s] = 8'd0; tw[s] = 8'd0; th[s] = 8'd0; tc[s] = 3'd0; tr[s] = 1'b0;
    end
  endtask

  // Reference: straight geometric rule over the whole table, saturate at the end.
  task automatic model(input int dw, output int dmg, output int hl, output int msk);
    int px, py, pw, ph, bx, by, bw, bh;
    dmg = 0; hl = 0; msk = 0;
    px = player_x; py = player_y; pw = player_w; ph = player_h;
    for (int s = 0; s < 8; s++) begin
      bx = tx[s]; by = ty[s]; bw = tw[s]; bh = th[s];
      if (tr[s] && pw > 0 && ph > 0 && bw > 0 && bh > 0 &&
          bx < px + pw && px < bx + bw && by < py + ph && py < by + bh) begin
        if (tc[s] == 3'd0) begin dmg += dw; msk |= (1 << s); end
        else if (tc[s] == 3'd2 && player_moving) begin dmg += 4; msk |= (1 << s); end
        else if (tc[s] == 3'd1) begin hl += 2; msk |= (1 << s); end
      end
    end
    if (dmg > 255) dmg = 255;
    if (hl > 255) hl = 255;
  endtask

  // One full scan from an idle DUT, checking index sequence, busy window and
  // single done pulse, then the results. Optionally scrambles player inputs mid-scan.
  task automatic run_scan(input bit perturb, input int e_dmg, input int e_heal, input int e_mask,
                          input bit chk_b, input int b_dmg, input int b_heal, input int b_mask);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("busy_in_scan", busy_a, 1);
      check("done_timing", done_a, (k == 9) ? 1 : 0);
      if (k <= 7) check("bul_index_seq", idx_a, k);
      if (perturb && k == 2) begin
        player_x = ~player_x; player_y = ~player_y;
        player_w = player_w + 8'd37; player_moving = ~player_moving;
      end
      if (k < 9) begin @(posedge clk); #1; end
    end
    check("damage", dmg_a, e_dmg);
    check("heal", heal_a, e_heal);
    check("hit_mask", mask_a, e_mask);
    if (chk_b) begin
      check("sat_damage", dmg_b, b_dmg);
      check("sat_heal", heal_b, b_heal);
      check("sat_hit_mask", mask_b, b_mask);
    end
    @(posedge clk); #1;
    check("busy_after", busy_a, 0);
    check("done_after", done_a, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d, h, m, d2, h2, m2, ndone, last_t, intervals;
    rst_n = 1'b0; start = 1'b0;
    player_x = 8'd0; player_y = 8'd0; player_w = 8'd0; player_h = 8'd0; player_moving = 1'b0;
    clear_table();

    // Slot 0 only; player box (16,16,16,16) unless stated.
    vecs[0]  = '{8'd16, 8'd16, 8'd16, 8'd16, 1'b0, 8'd32, 8'd20, 8'd8, 8'd8, 3'd0, 1'b1, 0, 0, 0};
    vecs[1]  = '{8'd16, 8'd16, 8'd16, 8'd16, 1'b0, 8'd31, 8'd20, 8'd8, 8'd8, 3'd0, 1'b1, 4, 0, 1};
    vecs[2]  = '{8'd16, 8'd16, 8'd16, 8'd16, 1'b0, 8'd20, 8'd20, 8'd8, 8'd8, 3'd2, 1'b1, 0, 0, 0};
    vecs[3]  = '{8'd16, 8'd16, 8'd16, 8'd16, 1'b1, 8'd20, 8'd20, 8'd8, 8'd8, 3'd2, 1'b1, 4, 0, 1};
    vecs[4]  = '{8'd16, 8'd16, 8'd16, 8'd16, 1'b0, 8'd20, 8'd20, 8'd8, 8'd8, 3'd1, 1'b1, 0, 2, 1};
    vecs[5]  = '{8'd16, 8'd16, 8'd16, 8'd16, 1'b1, 8'd20, 8'd20, 8'd8, 8'd8, 3'd3, 1'b1, 0, 0, 0};
    vecs[6]  = '{8'd16, 8'd16, 8'd16, 8'd16, 1'b0, 8'd20, 8'd20, 8'd8, 8'd8, 3'd0, 1'b0, 0, 0, 0};
    vecs[7]  = '{8'd16, 8'd16, 8'd0,  8'd16, 1'b0, 8'd20, 8'd20, 8'd8, 8'd8, 3'd0, 1'b1, 0, 0, 0};
    vecs[8]  = '{8'd16, 8'd16, 8'd16, 8'd16, 1'b0, 8'd20, 8'd20, 8'd0, 8'd8, 3'd0, 1'b1, 0, 0, 0};
    vecs[9]  = '{8'd16, 8'd16, 8'd16, 8'd16, 1'b0, 8'd8,  8'd20, 8'd8, 8'd8, 3'd0, 1'b1, 0, 0, 0};
    vecs[10] = '{8'd16, 8'd16, 8'd16, 8'd16, 1'b0, 8'd9,  8'd31, 8'd8, 8'd8, 3'd0, 1'b1, 4, 0, 1};
    vecs[11] = '{8'd250, 8'd250, 8'd200, 8'd200, 1'b0, 8'd10, 8'd10, 8'd8, 8'd8, 3'd0, 1'b1, 0, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    check("reset_index", idx_a, 0);
    check("reset_damage", dmg_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      clear_table();
      player_x = vecs[i].px; player_y = vecs[i].py; player_w = vecs[i].pw; player_h = vecs[i].ph;
      player_moving = vecs[i].mv;
      tx[0] = vecs[i].bx; ty[0] = vecs[i].by; tw[0] = vecs[i].bw; th[0] = vecs[i].bh;
      tc[0] = vecs[i].col; tr[0] = vecs[i].rnd;
      run_scan(1'b0, vecs[i].e_dmg, vecs[i].e_heal, vecs[i].e_mask, 1'b0, 0, 0, 0);
    end

    // White slot0 and green slot1 against the standard box.
    clear_table();
    player_x = 8'd16; player_y = 8'd16; player_w = 8'd16; player_h = 8'd16; player_moving = 1'b0;
    tx[0] = 8'd20; ty[0] = 8'd20; tw[0] = 8'd8; th[0] = 8'd8; tc[0] = 3'd0; tr[0] = 1'b1;
    tx[1] = 8'd10; ty[1] = 8'd10; tw[1] = 8'd8; th[1] = 8'd8; tc[1] = 3'd1; tr[1] = 1'b1;
    run_scan(1'b0, 4, 2, 8'b0000_0011, 1'b1, 40, 2, 8'b0000_0011);

    // Async reset mid-scan wipes held results at once.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", busy_a, 0);
    check("midreset_done", done_a, 0);
    check("midreset_index", idx_a, 0);
    check("midreset_damage", dmg_a, 0);
    check("midreset_heal", heal_a, 0);
    check("midreset_mask", mask_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All eight white bullets overlapping: saturating sum.
    for (int s = 0; s < 8; s++) begin
      tx[s] = 8'd18 + 8'(s); ty[s] = 8'd18; tw[s] = 8'd4; th[s] = 8'd4; tc[s] = 3'd0; tr[s] = 1'b1;
    end
    run_scan(1'b0, 32, 0, 8'hFF, 1'b1, 255, 0, 8'hFF);

    // Start re-pulsed mid-scan is ignored.
    ndone = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) start = 1'b1;
      if (c == 5) start = 1'b0;
      if (done_a) ndone++;
      @(posedge clk); #1;
    end
    check("repulse_single_done", ndone, 1);
    check("repulse_idle", busy_a, 0);

    // Start held high: back-to-back scans, done every 11 cycles.
    ndone = 0; last_t = -1; intervals = 0;
    start = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (done_a) begin
        ndone++;
        if (last_t >= 0) begin
          check("held_done_period", c - last_t, 11);
          intervals++;
        end
        last_t = c;
      end
    end
    start = 1'b0;
    check("held_done_count", ndone, 4);
    repeat (12) @(posedge clk);
    #1;

    // Randomized scans, player inputs scrambled after latching.
    for (int it = 0; it < 40; it++) begin
      int lim;
      lim = (it % 2 == 0) ? 63 : 255;
      player_x = 8'($urandom_range(0, lim)); player_y = 8'($urandom_range(0, lim));
      player_w = 8'($urandom_range(0, lim)); player_h = 8'($urandom_range(0, lim));
      player_moving = 1'($urandom_range(0, 1));
      for (int s = 0; s < 8; s++) begin
        tx[s] = 8'($urandom_range(0, lim)); ty[s] = 8'($urandom_range(0, lim));
        tw[s] = 8'($urandom_range(0, lim)); th[s] = 8'($urandom_range(0, lim));
        tc[s] = 3'($urandom_range(0, 7)); tr[s] = ($urandom_range(0, 3) != 0);
      end
      model(4, d, h, m);
      model(40, d2, h2, m2);
      run_scan(1'b1, d, h, m, 1'b1, d2, h2, m2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
